// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand-forwarding and hazard checker that sits beside the ID stage.
//   For each decoded source register it picks where the operand comes from
//   (register file or one of NSTAGE downstream stages), decides whether the
//   instruction may issue, tracks the multi-cycle HI/LO multiply/divide unit
//   and keeps a saturating count of stalled cycles.
//
// Ports:
//   clk, resetn   clock (rising edge), asynchronous active-low reset
//   stage_dest    destination register of stage k at [5k+4:5k]
//   stage_wen     stage k holds a valid register write
//   stage_rdy     stage k result can be forwarded now
//   id_src        source register j at [5j+4:5j]
//   id_need       source j is actually read
//   id_valid      ID holds a valid instruction
//   id_md_op      instruction starts a multiply/divide
//   id_is_div     with id_md_op: divide, else multiply
//   id_hilo_rd    instruction reads HI/LO
//   cnt_clr       synchronous clear of stall_cnt
//   src_sel       per source: 0 = regfile, k+1 = stage k
//   id_ready      instruction may issue this cycle
//   md_busy       HI/LO unit busy
//   stall_cnt     cycles with id_valid=1 and id_ready=0 (saturating)

module fwd_hazard_unit #(
  parameter int NSRC    = 2,
  parameter int NSTAGE  = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int SELW    = $clog2(NSTAGE + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NSTAGE*5-1:0]    stage_dest,
  input  logic [NSTAGE-1:0]      stage_wen,
  input  logic [NSTAGE-1:0]      stage_rdy,
  input  logic [NSRC*5-1:0]      id_src,
  input  logic [NSRC-1:0]        id_need,
  input  logic                   id_valid,
  input  logic                   id_md_op,
  input  logic                   id_is_div,
  input  logic                   id_hilo_rd,
  input  logic                   cnt_clr,
  output logic [NSRC*SELW-1:0]   src_sel,
  output logic                   id_ready,
  output logic                   md_busy,
  output logic [31:0]            stall_cnt
);

  localparam logic [7:0] MulLat8 = 8'(MUL_LAT);
  localparam logic [7:0] DivLat8 = 8'(DIV_LAT);

  logic        data_ok;
  logic        md_ok;
  logic        issue;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic        md_busy_q;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Forwarding select: scan stages youngest first and stop at the first
  // match, so an older ready copy never hides a younger pending write.
  always_comb begin : fwd_sel
    logic found;
    src_sel = '0;
    data_ok = 1'b1;
    found   = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      found = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && id_need[j] && (id_src[5*j +: 5] != 5'd0) &&
            stage_wen[k] && (stage_dest[5*k +: 5] == id_src[5*j +: 5])) begin
          found = 1'b1;
          src_sel[SELW*j +: SELW] = SELW'(k + 1);
          if (!stage_rdy[k]) begin
            data_ok = 1'b0;
          end
        end
      end
    end
  end

  // Only instructions that touch HI/LO wait for the multiply/divide unit.
  always_comb begin
    md_ok    = !md_busy_q || !(id_md_op || id_hilo_rd);
    id_ready = data_ok && md_ok;
    issue    = id_valid && id_ready;
  end

  // HI/LO busy counter: loaded on md issue, counts down to zero otherwise.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue && id_md_op) begin
      md_cnt_d = id_is_div ? DivLat8 : MulLat8;
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  // Stall counter: clear wins over increment, and it sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = 32'd0;
    end else if (id_valid && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers; md_busy is registered from the next counter value so it
  // is high exactly while the counter holds a nonzero value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_cnt_q    <= 8'd0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= (md_cnt_d != 8'd0);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = md_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule
